// File: rtl/noc_switch_n_if.sv
// Upstream and per-child byte-stream bundle for noc_switch_n.
// master drives requests/child responses; slave is the switch side.
interface noc_switch_n_if #(
    parameter int NPORTS = 4
) ();
    logic                to_ctl;
    logic [7:0]          to_data;
    logic                from_ctl;
    logic [7:0]          from_data;
    logic [NPORTS-1:0]   chl_to_ctl;
    logic [8*NPORTS-1:0] chl_to_data;
    logic [NPORTS-1:0]   chl_from_ctl;
    logic [8*NPORTS-1:0] chl_from_data;
    logic [NPORTS-1:0]   ovf;

    modport master (
        output to_ctl, to_data, chl_from_ctl, chl_from_data,
        input  from_ctl, from_data, chl_to_ctl, chl_to_data, ovf
    );

    modport slave (
        input  to_ctl, to_data, chl_from_ctl, chl_from_data,
        output from_ctl, from_data, chl_to_ctl, chl_to_data, ovf
    );
endinterface

// File: rtl/noc_switch_n.sv
// NoC switch: routes upstream request packets to NPORTS children by destination ID and returns
// buffered child response packets upstream round-robin. Option macro: NOC_SW_BCAST_EN (dest 8'hFF to all).
module noc_switch_n #(
    parameter int         NPORTS     = 4,
    parameter logic [7:0] BASE_ID    = 8'h40,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    noc_switch_n_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [1:0] RT_IDLE = 2'd0;
    localparam logic [1:0] RT_DEST = 2'd1;
    localparam logic [1:0] RT_FWD  = 2'd2;
    localparam logic [1:0] RT_DROP = 2'd3;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_SEND = 1'b1;

    logic [1:0]          rt_state_r;
    logic [7:0]          cmd_r;
    logic [NPORTS-1:0]   sel_mask_r;
    logic                s1_vld_r;
    logic                s1_ctl_r;
    logic [7:0]          s1_data_r;
    logic [NPORTS-1:0]   chl_ctl_r;
    logic [8*NPORTS-1:0] chl_data_r;

    logic                req_cmd_s;
    logic                req_pay_s;
    logic                bcast_s;
    logic                emit_cmd_s;
    logic [7:0]          dest_off_s;
    logic [NPORTS-1:0]   dest_mask_s;
    logic [NPORTS-1:0]   chl_ctl_s;
    logic [8*NPORTS-1:0] chl_data_s;

    logic [8:0]          mem_r     [NPORTS][FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r  [NPORTS];
    logic [AW-1:0]       rd_ptr_r  [NPORTS];
    logic [CW-1:0]       cnt_r     [NPORTS];
    logic [CW-1:0]       pkt_cnt_r [NPORTS];
    logic [NPORTS-1:0]   open_r;
    logic [NPORTS-1:0]   ovf_r;

    logic [8:0]          rsp_word_s [NPORTS];
    logic [8:0]          head_s     [NPORTS];
    logic [NPORTS-1:0]   rsp_nop_s, full_s, push_s, drop_s, close_s, pop_s, last_s, stop_s;

    logic                arb_state_r;
    logic [PW-1:0]       grant_r;
    logic [PW-1:0]       rr_ptr_r;
    logic                from_ctl_r;
    logic [7:0]          from_data_r;
    logic                found_s;
    logic [PW-1:0]       pick_s;

    // Classify the upstream byte and decode it as a destination mask.
    always_comb begin
        req_cmd_s  = bus.to_ctl && (bus.to_data != 8'h00);
        req_pay_s  = !bus.to_ctl;
        dest_off_s = bus.to_data - BASE_ID;
`ifdef NOC_SW_BCAST_EN
        bcast_s    = (bus.to_data == 8'hFF);
`else
        bcast_s    = 1'b0;
`endif
        for (int p = 0; p < NPORTS; p++) begin
            dest_mask_s[p] = bcast_s || (dest_off_s == 8'(p));
        end
        emit_cmd_s = (rt_state_r == RT_DEST) && req_pay_s && (dest_mask_s != {NPORTS{1'b0}});
    end

    // Next child bytes: the held cmd goes out on the decode cycle so it keeps its 2-cycle slot.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            if (emit_cmd_s && dest_mask_s[p]) begin
                chl_ctl_s[p]          = 1'b1;
                chl_data_s[8*p +: 8]  = cmd_r;
            end else if (s1_vld_r && sel_mask_r[p]) begin
                chl_ctl_s[p]          = s1_ctl_r;
                chl_data_s[8*p +: 8]  = s1_data_r;
            end else begin
                chl_ctl_s[p]          = 1'b1;
                chl_data_s[8*p +: 8]  = 8'h00;
            end
        end
    end

    // Request route FSM, one-byte delay stage and registered child outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rt_state_r <= RT_IDLE;
            cmd_r      <= 8'h00;
            sel_mask_r <= {NPORTS{1'b0}};
            s1_vld_r   <= 1'b0;
            s1_ctl_r   <= 1'b1;
            s1_data_r  <= 8'h00;
            chl_ctl_r  <= {NPORTS{1'b1}};
            chl_data_r <= {(8*NPORTS){1'b0}};
        end else begin
            chl_ctl_r  <= chl_ctl_s;
            chl_data_r <= chl_data_s;
            s1_vld_r   <= 1'b0;
            s1_ctl_r   <= bus.to_ctl;
            s1_data_r  <= bus.to_data;
            case (rt_state_r)
                RT_IDLE: begin
                    if (req_cmd_s) begin
                        cmd_r      <= bus.to_data;
                        rt_state_r <= RT_DEST;
                    end
                end
                RT_DEST: begin
                    if (req_cmd_s) begin
                        cmd_r <= bus.to_data;
                    end else if (req_pay_s) begin
                        if (dest_mask_s != {NPORTS{1'b0}}) begin
                            sel_mask_r <= dest_mask_s;
                            s1_vld_r   <= 1'b1;
                            rt_state_r <= RT_FWD;
                        end else begin
                            rt_state_r <= RT_DROP;
                        end
                    end
                end
                RT_FWD: begin
                    if (req_cmd_s) begin
                        cmd_r      <= bus.to_data;
                        rt_state_r <= RT_DEST;
                    end else begin
                        s1_vld_r   <= 1'b1;
                    end
                end
                RT_DROP: begin
                    if (req_cmd_s) begin
                        cmd_r      <= bus.to_data;
                        rt_state_r <= RT_DEST;
                    end
                end
                default: rt_state_r <= RT_IDLE;
            endcase
        end
    end

    // Per-port response capture and drain controls; a packet ends where the next head is a cmd or the FIFO runs dry.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            rsp_word_s[p] = {bus.chl_from_ctl[p], bus.chl_from_data[8*p +: 8]};
            rsp_nop_s[p]  = bus.chl_from_ctl[p] && (bus.chl_from_data[8*p +: 8] == 8'h00);
            full_s[p]     = (cnt_r[p] == CW'(FIFO_DEPTH));
            push_s[p]     = !rsp_nop_s[p] && !full_s[p];
            drop_s[p]     = !rsp_nop_s[p] && full_s[p];
            close_s[p]    = open_r[p] && bus.chl_from_ctl[p];
            pop_s[p]      = (arb_state_r == ARB_SEND) && (grant_r == PW'(p));
            head_s[p]     = mem_r[p][rd_ptr_r[p]];
            last_s[p]     = (cnt_r[p] == CW'(1)) || mem_r[p][rd_ptr_r[p] + AW'(1)][8];
            stop_s[p]     = pop_s[p] && last_s[p];
        end
    end

    // Response FIFO pointers, occupancy, closed-packet counts and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr_r[p]  <= {AW{1'b0}};
                rd_ptr_r[p]  <= {AW{1'b0}};
                cnt_r[p]     <= {CW{1'b0}};
                pkt_cnt_r[p] <= {CW{1'b0}};
            end
            open_r <= {NPORTS{1'b0}};
            ovf_r  <= {NPORTS{1'b0}};
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push_s[p]) wr_ptr_r[p] <= wr_ptr_r[p] + AW'(1);
                if (pop_s[p])  rd_ptr_r[p] <= rd_ptr_r[p] + AW'(1);
                cnt_r[p]     <= cnt_r[p] + CW'(push_s[p]) - CW'(pop_s[p]);
                pkt_cnt_r[p] <= pkt_cnt_r[p] + CW'(close_s[p]) - CW'(stop_s[p]);
                open_r[p]    <= !rsp_nop_s[p];
                if (drop_s[p]) ovf_r[p] <= 1'b1;
            end
        end
    end

    // Response storage; entries are only meaningful between the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (push_s[p]) mem_r[p][wr_ptr_r[p]] <= rsp_word_s[p];
        end
    end

    // Round-robin search from rr_ptr for a port holding a complete packet.
    always_comb begin : grant_search
        int   idx;
        logic hit;
        found_s = 1'b0;
        pick_s  = rr_ptr_r;
        for (int i = 0; i < NPORTS; i++) begin
            idx     = (int'(rr_ptr_r) + i) % NPORTS;
            hit     = !found_s && (pkt_cnt_r[idx] != {CW{1'b0}});
            pick_s  = hit ? PW'(idx) : pick_s;
            found_s = found_s || hit;
        end
    end

    // Upstream arbiter: the IDLE cycle doubles as the NOP gap between packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_state_r <= ARB_IDLE;
            grant_r     <= {PW{1'b0}};
            rr_ptr_r    <= {PW{1'b0}};
            from_ctl_r  <= 1'b1;
            from_data_r <= 8'h00;
        end else begin
            case (arb_state_r)
                ARB_IDLE: begin
                    from_ctl_r  <= 1'b1;
                    from_data_r <= 8'h00;
                    if (found_s) begin
                        grant_r     <= pick_s;
                        arb_state_r <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    {from_ctl_r, from_data_r} <= head_s[grant_r];
                    if (last_s[grant_r]) begin
                        rr_ptr_r    <= (grant_r == PW'(NPORTS - 1)) ? {PW{1'b0}} : grant_r + PW'(1);
                        arb_state_r <= ARB_IDLE;
                    end
                end
                default: begin
                    from_ctl_r  <= 1'b1;
                    from_data_r <= 8'h00;
                    arb_state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.chl_to_ctl  = chl_ctl_r;
    assign bus.chl_to_data = chl_data_r;
    assign bus.from_ctl    = from_ctl_r;
    assign bus.from_data   = from_data_r;
    assign bus.ovf         = ovf_r;
endmodule
